pipmem_rv32: RTL and testbench

- Memory-access stage between the Execute stage and write-back.
- Consumes Execute outputs: memory request flag, read/write, address, store data, destination register data/address, 5-bit memory type code.
- Performs load/store transactions on a single-master request/acknowledge data bus, with byte-lane steering and load sign/zero extension.
- Passes non-memory results through to write-back; stalls upstream while a bus transaction is outstanding.

---
 rtl/pipmem_rv32.sv | 151 +++++++++++++++
 tb/tb_pipmem_rv32.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipmem_rv32.sv
// Memory-access stage: pass-through of ALU results, load/store over a req/ack bus with lane
// steering, load extension, alignment/type checks and a transaction timeout.
module pipmem_rv32 #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMEM,
    input  logic        iRW,
    input  logic [31:0] iMEMADDR,
    input  logic [31:0] iMEMDATA,
    input  logic [31:0] iDregDATA,
    input  logic [4:0]  iDregADDR,
    input  logic [4:0]  iDecodedOP,
    input  logic [31:0] iBUSRDATA,
    input  logic        iBUSACK,
    output logic        oBUSREQ,
    output logic        oBUSWE,
    output logic [31:0] oBUSADDR,
    output logic [31:0] oBUSWDATA,
    output logic [3:0]  oBUSBE,
    output logic [31:0] oDregDATA,
    output logic [4:0]  oDregADDR,
    output logic        oWBEN,
    output logic        oSTALL,
    output logic        oMISALIGN,
    output logic        oBUSERR
);

    typedef enum logic {Idle, Busy} state_t;

    localparam logic [CNTW-1:0] LastCnt = CNTW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [1:0]      offLat;
    logic [4:0]      opLat;
    logic            rwLat;
    logic [4:0]      dregLat;

    logic        oneHot;
    logic        illegal;
    logic        misalign;
    logic        timeoutHit;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [31:0] loadLane;
    logic [31:0] loadExt;

    assign oneHot     = (iDecodedOP != 5'd0) && ((iDecodedOP & (iDecodedOP - 5'd1)) == 5'd0);
    assign illegal    = !oneHot || (!iRW && (iDecodedOP[3] || iDecodedOP[4]));
    assign misalign   = ((iDecodedOP[1] || iDecodedOP[4]) && iMEMADDR[0]) ||
                        (iDecodedOP[2] && (iMEMADDR[1:0] != 2'b00));
    assign timeoutHit = (TIMEOUT != 0) && (cnt == LastCnt);
    assign oSTALL     = (state == Busy);

    always_comb begin
        reqBe    = 4'b1111;
        reqWdata = iMEMDATA;
        if (!iRW) begin
            if (iDecodedOP[0]) begin
                reqBe    = 4'b0001 << iMEMADDR[1:0];
                reqWdata = {4{iMEMDATA[7:0]}};
            end else if (iDecodedOP[1]) begin
                reqBe    = 4'b0011 << iMEMADDR[1:0];
                reqWdata = {2{iMEMDATA[15:0]}};
            end
        end
    end

    // Shift the addressed byte/half down to bit 0 before extending.
    assign loadLane = iBUSRDATA >> {offLat, 3'b000};

    always_comb begin
        loadExt = loadLane;
        if (opLat[0])      loadExt = {{24{loadLane[7]}}, loadLane[7:0]};
        else if (opLat[1]) loadExt = {{16{loadLane[15]}}, loadLane[15:0]};
        else if (opLat[3]) loadExt = {24'd0, loadLane[7:0]};
        else if (opLat[4]) loadExt = {16'd0, loadLane[15:0]};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= Idle;
            cnt       <= '0;
            offLat    <= 2'b00;
            opLat     <= 5'd0;
            rwLat     <= 1'b0;
            dregLat   <= 5'd0;
            oBUSREQ   <= 1'b0;
            oBUSWE    <= 1'b0;
            oBUSADDR  <= 32'd0;
            oBUSWDATA <= 32'd0;
            oBUSBE    <= 4'd0;
            oDregDATA <= 32'd0;
            oDregADDR <= 5'd0;
            oWBEN     <= 1'b0;
            oMISALIGN <= 1'b0;
            oBUSERR   <= 1'b0;
        end else begin
            oWBEN     <= 1'b0;
            oMISALIGN <= 1'b0;
            oBUSERR   <= 1'b0;
            case (state)
                Idle: begin
                    if (!iMEM) begin
                        oDregDATA <= iDregDATA;
                        oDregADDR <= iDregADDR;
                        oWBEN     <= (iDregADDR != 5'd0);
                    end else if (illegal) begin
                        oBUSERR <= 1'b1;
                    end else if (misalign) begin
                        oMISALIGN <= 1'b1;
                    end else begin
                        oBUSREQ   <= 1'b1;
                        oBUSWE    <= ~iRW;
                        oBUSADDR  <= {iMEMADDR[31:2], 2'b00};
                        oBUSBE    <= reqBe;
                        oBUSWDATA <= reqWdata;
                        offLat    <= iMEMADDR[1:0];
                        opLat     <= iDecodedOP;
                        rwLat     <= iRW;
                        dregLat   <= iDregADDR;
                        cnt       <= '0;
                        state     <= Busy;
                    end
                end
                Busy: begin
                    cnt <= cnt + 1'b1;
                    // Ack takes priority over a coincident timeout.
                    if (iBUSACK) begin
                        oBUSREQ <= 1'b0;
                        state   <= Idle;
                        if (rwLat) begin
                            oDregDATA <= loadExt;
                            oDregADDR <= dregLat;
                            oWBEN     <= (dregLat != 5'd0);
                        end
                    end else if (timeoutHit) begin
                        oBUSREQ <= 1'b0;
                        oBUSERR <= 1'b1;
                        state   <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipmem_rv32.sv
// Directed bench for pipmem_rv32: pass-through, loads, stores, checks, timeout and reset.
module tb_pipmem_rv32;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iMEM = 1'b0;
    logic        iRW = 1'b0;
    logic [31:0] iMEMADDR = 32'd0;
    logic [31:0] iMEMDATA = 32'd0;
    logic [31:0] iDregDATA = 32'd0;
    logic [4:0]  iDregADDR = 5'd0;
    logic [4:0]  iDecodedOP = 5'd0;
    logic [31:0] iBUSRDATA = 32'd0;
    logic        iBUSACK = 1'b0;
    logic        oBUSREQ, oBUSWE, oWBEN, oSTALL, oMISALIGN, oBUSERR;
    logic [31:0] oBUSADDR, oBUSWDATA, oDregDATA;
    logic [3:0]  oBUSBE;
    logic [4:0]  oDregADDR;

    int tests = 0;
    int fails = 0;
    int n;

    pipmem_rv32 #(.TIMEOUT(4), .CNTW(3)) dut (
        .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW), .iMEMADDR(iMEMADDR),
        .iMEMDATA(iMEMDATA), .iDregDATA(iDregDATA), .iDregADDR(iDregADDR),
        .iDecodedOP(iDecodedOP), .iBUSRDATA(iBUSRDATA), .iBUSACK(iBUSACK),
        .oBUSREQ(oBUSREQ), .oBUSWE(oBUSWE), .oBUSADDR(oBUSADDR), .oBUSWDATA(oBUSWDATA),
        .oBUSBE(oBUSBE), .oDregDATA(oDregDATA), .oDregADDR(oDregADDR), .oWBEN(oWBEN),
        .oSTALL(oSTALL), .oMISALIGN(oMISALIGN), .oBUSERR(oBUSERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one memory instruction for a single edge, then an idle ALU op with rd = x0.
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] op, input logic [4:0] rd);
        iMEM = 1'b1; iRW = rw; iMEMADDR = addr; iMEMDATA = data;
        iDecodedOP = op; iDregADDR = rd;
        tick();
        iMEM = 1'b0; iDregADDR = 5'd0; iDregDATA = 32'd0;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_req", 32'(oBUSREQ), 32'd0);
        chk("rst_stall", 32'(oSTALL), 32'd0);
        chk("rst_wben", 32'(oWBEN), 32'd0);
        chk("rst_be", 32'(oBUSBE), 32'd0);
        chk("rst_dreg", oDregDATA, 32'd0);
        chk("rst_addr", oBUSADDR, 32'd0);
        iRST = 1'b0;

        // ALU pass-through
        iDregDATA = 32'h1234_5678; iDregADDR = 5'd5;
        tick();
        chk("alu_data", oDregDATA, 32'h1234_5678);
        chk("alu_addr", 32'(oDregADDR), 32'd5);
        chk("alu_wben", 32'(oWBEN), 32'd1);
        iDregADDR = 5'd0;
        tick();
        chk("alu_x0_wben", 32'(oWBEN), 32'd0);
        chk("alu_x0_addr", 32'(oDregADDR), 32'd0);

        // Load byte signed at 0x103, ack in the third busy cycle
        issue(1'b1, 32'h103, 32'd0, 5'b00001, 5'd7);
        chk("lb_req", 32'(oBUSREQ), 32'd1);
        chk("lb_we", 32'(oBUSWE), 32'd0);
        chk("lb_addr", oBUSADDR, 32'h100);
        chk("lb_be", 32'(oBUSBE), 32'hF);
        chk("lb_stall1", 32'(oSTALL), 32'd1);
        tick();
        chk("lb_stall2", 32'(oSTALL), 32'd1);
        tick();
        chk("lb_stall3", 32'(oSTALL), 32'd1);
        iBUSACK = 1'b1; iBUSRDATA = 32'h80AB_CDEF;
        tick();
        iBUSACK = 1'b0;
        chk("lb_data", oDregDATA, 32'hFFFF_FF80);
        chk("lb_rd", 32'(oDregADDR), 32'd7);
        chk("lb_wben", 32'(oWBEN), 32'd1);
        chk("lb_stall_off", 32'(oSTALL), 32'd0);
        chk("lb_req_off", 32'(oBUSREQ), 32'd0);
        tick();
        chk("lb_wben_pulse", 32'(oWBEN), 32'd0);

        // Load byte unsigned, same address and data
        issue(1'b1, 32'h103, 32'd0, 5'b01000, 5'd8);
        tick(); tick();
        iBUSACK = 1'b1;
        tick();
        iBUSACK = 1'b0;
        chk("lbu_data", oDregDATA, 32'h0000_0080);
        chk("lbu_wben", 32'(oWBEN), 32'd1);

        // Load half signed from upper lane
        iBUSRDATA = 32'h8001_7FFF;
        issue(1'b1, 32'h202, 32'd0, 5'b00010, 5'd9);
        iBUSACK = 1'b1;
        tick();
        iBUSACK = 1'b0;
        chk("lh_data", oDregDATA, 32'hFFFF_8001);

        // Store half at 0x202; upstream holds an ALU op during the transaction
        issue(1'b0, 32'h202, 32'h0000_BEEF, 5'b00010, 5'd0);
        iDregDATA = 32'h0000_CAFE; iDregADDR = 5'd4;
        chk("sh_we", 32'(oBUSWE), 32'd1);
        chk("sh_be", 32'(oBUSBE), 32'b1100);
        chk("sh_wdata", oBUSWDATA, 32'hBEEF_BEEF);
        chk("sh_addr", oBUSADDR, 32'h200);
        tick();
        iBUSACK = 1'b1;
        tick();
        iBUSACK = 1'b0;
        chk("sh_wben", 32'(oWBEN), 32'd0);
        chk("sh_req_off", 32'(oBUSREQ), 32'd0);
        tick();
        chk("b2b_data", oDregDATA, 32'h0000_CAFE);
        chk("b2b_wben", 32'(oWBEN), 32'd1);
        iDregADDR = 5'd0;

        // Store byte lane steering
        issue(1'b0, 32'h301, 32'h0000_00A5, 5'b00001, 5'd0);
        chk("sb_be", 32'(oBUSBE), 32'b0010);
        chk("sb_wdata", oBUSWDATA, 32'hA5A5_A5A5);
        iBUSACK = 1'b1;
        tick();
        iBUSACK = 1'b0;

        // Misaligned word load
        issue(1'b1, 32'h101, 32'd0, 5'b00100, 5'd3);
        chk("mis_flag", 32'(oMISALIGN), 32'd1);
        chk("mis_req", 32'(oBUSREQ), 32'd0);
        chk("mis_wben", 32'(oWBEN), 32'd0);
        chk("mis_stall", 32'(oSTALL), 32'd0);
        tick();
        chk("mis_pulse", 32'(oMISALIGN), 32'd0);

        // Illegal: store with HU, then a non-one-hot load
        issue(1'b0, 32'h200, 32'd0, 5'b10000, 5'd0);
        chk("ill_hu_err", 32'(oBUSERR), 32'd1);
        chk("ill_hu_req", 32'(oBUSREQ), 32'd0);
        tick();
        chk("ill_pulse", 32'(oBUSERR), 32'd0);
        issue(1'b1, 32'h200, 32'd0, 5'b00011, 5'd2);
        chk("ill_oh_err", 32'(oBUSERR), 32'd1);
        chk("ill_oh_req", 32'(oBUSREQ), 32'd0);

        // Timeout with no ack
        issue(1'b1, 32'h300, 32'd0, 5'b00100, 5'd9);
        n = 0;
        while (oBUSREQ && n < 10) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(oBUSERR), 32'd1);
        chk("to_stall", 32'(oSTALL), 32'd0);
        chk("to_wben", 32'(oWBEN), 32'd0);
        tick();
        chk("to_err_pulse", 32'(oBUSERR), 32'd0);

        // Reset in the second busy cycle discards the load
        issue(1'b1, 32'h400, 32'd0, 5'b00100, 5'd3);
        tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        chk("rmid_req", 32'(oBUSREQ), 32'd0);
        chk("rmid_stall", 32'(oSTALL), 32'd0);
        iBUSACK = 1'b1; iBUSRDATA = 32'h1111_1111;
        tick();
        iBUSACK = 1'b0;
        chk("rmid_wben", 32'(oWBEN), 32'd0);
        chk("rmid_data", oDregDATA, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
